// File: rtl/xgs_stream_pkg.sv
// Shared stream definitions: tuser flag positions, streamer state encoding
// and the eight-pixel ramp beat builder.
package xgs_stream_pkg;

  localparam int unsigned TUSER_SOF = 0;
  localparam int unsigned TUSER_EOF = 1;
  localparam int unsigned TUSER_SOL = 2;
  localparam int unsigned TUSER_EOL = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } stream_state_e;

  // Byte k carries pixel beat*8+k plus the row bias; pixels past the row end read as zero.
  function automatic logic [63:0] build_beat(input logic [31:0] beat_idx,
                                             input logic [31:0] x_size,
                                             input logic [7:0]  row_add);
    logic [63:0] data;
    logic [31:0] px;
    data = 64'd0;
    for (int k = 0; k < 8; k++) begin
      px = (beat_idx << 3) + 32'(k);
      if (px < x_size) begin
        data[k*8 +: 8] = px[7:0] + row_add;
      end else begin
        data[k*8 +: 8] = 8'd0;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/x_ramp_streamer.sv
// Frame generator: streams an x/y ramp test pattern as 64-bit AXI-stream beats
// with SOF/EOF/SOL/EOL flags, tlast per row and programmable inter-row gaps.
module x_ramp_streamer
  import xgs_stream_pkg::*;
#(
  parameter int X_SIZE_W = 16,
  parameter int Y_SIZE_W = 16
) (
  input  logic                aclk,
  input  logic                aclk_reset,
  input  logic                aclk_start,
  input  logic [X_SIZE_W-1:0] aclk_x_size,
  input  logic [Y_SIZE_W-1:0] aclk_y_size,
  input  logic [15:0]         aclk_line_gap,
  input  logic                aclk_row_offset,
  input  logic                aclk_tready,
  output logic                aclk_tvalid,
  output logic [63:0]         aclk_tdata,
  output logic [3:0]          aclk_tuser,
  output logic                aclk_tlast,
  output logic                aclk_busy,
  output logic                aclk_frame_done
);

  localparam logic [X_SIZE_W-1:0] BEAT_ZERO = {X_SIZE_W{1'b0}};
  localparam logic [X_SIZE_W-1:0] BEAT_ONE  = {{(X_SIZE_W-1){1'b0}}, 1'b1};
  localparam logic [Y_SIZE_W-1:0] ROW_ZERO  = {Y_SIZE_W{1'b0}};
  localparam logic [Y_SIZE_W-1:0] ROW_ONE   = {{(Y_SIZE_W-1){1'b0}}, 1'b1};

  stream_state_e state, state_nxt;

  logic [X_SIZE_W-1:0] beat, beat_nxt;
  logic [Y_SIZE_W-1:0] row, row_nxt;
  logic [15:0]         gap_cnt, gap_nxt;
  logic                load;

  logic [X_SIZE_W-1:0] x_q, last_beat_q;
  logic [Y_SIZE_W-1:0] last_row_q;
  logic [15:0]         gap_q;
  logic                offset_q;

  logic [X_SIZE_W-1:0] x_cur, last_beat_cur;
  logic [Y_SIZE_W-1:0] last_row_cur;
  logic                offset_cur;

  logic                valid_nxt;
  logic [63:0]         data_nxt;
  logic [3:0]          user_nxt;
  logic                last_nxt;

  // Frame state register.
  always_ff @(posedge aclk or posedge aclk_reset) begin
    if (aclk_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and counter updates; the last beat is floor((x-1)/8) = ceil(x/8)-1.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    row_nxt   = row;
    gap_nxt   = gap_cnt;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aclk_start && (aclk_x_size != BEAT_ZERO) && (aclk_y_size != ROW_ZERO)) begin
          state_nxt = ST_ROW;
          beat_nxt  = BEAT_ZERO;
          row_nxt   = ROW_ZERO;
          load      = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ROW: begin
        if (aclk_tvalid && aclk_tready) begin
          if (beat == last_beat_q) begin
            beat_nxt = BEAT_ZERO;
            if (row == last_row_q) begin
              state_nxt = ST_DONE;
            end else if (gap_q != 16'd0) begin
              state_nxt = ST_GAP;
              row_nxt   = row + ROW_ONE;
              gap_nxt   = gap_q - 16'd1;
            end else begin
              state_nxt = ST_ROW;
              row_nxt   = row + ROW_ONE;
            end
          end else begin
            beat_nxt = beat + BEAT_ONE;
          end
        end else begin
          state_nxt = ST_ROW;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 16'd0) begin
          state_nxt = ST_ROW;
        end else begin
          gap_nxt = gap_cnt - 16'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Configuration as seen by the next beat: live inputs on the start cycle, latched copy after.
  always_comb begin
    if (load) begin
      x_cur         = aclk_x_size;
      last_beat_cur = (aclk_x_size - BEAT_ONE) >> 3;
      last_row_cur  = aclk_y_size - ROW_ONE;
      offset_cur    = aclk_row_offset;
    end else begin
      x_cur         = x_q;
      last_beat_cur = last_beat_q;
      last_row_cur  = last_row_q;
      offset_cur    = offset_q;
    end
  end

  // Counters and the configuration captured at frame acceptance.
  always_ff @(posedge aclk or posedge aclk_reset) begin
    if (aclk_reset) begin
      beat        <= BEAT_ZERO;
      row         <= ROW_ZERO;
      gap_cnt     <= 16'd0;
      x_q         <= BEAT_ZERO;
      last_beat_q <= BEAT_ZERO;
      last_row_q  <= ROW_ZERO;
      gap_q       <= 16'd0;
      offset_q    <= 1'b0;
    end else begin
      beat    <= beat_nxt;
      row     <= row_nxt;
      gap_cnt <= gap_nxt;
      if (load) begin
        x_q         <= x_cur;
        last_beat_q <= last_beat_cur;
        last_row_q  <= last_row_cur;
        gap_q       <= aclk_line_gap;
        offset_q    <= offset_cur;
      end
    end
  end

  // Beat contents for the next cycle; a stalled beat recomputes to the same value.
  always_comb begin
    valid_nxt = (state_nxt == ST_ROW);
    data_nxt  = 64'd0;
    user_nxt  = 4'b0000;
    last_nxt  = 1'b0;
    if (valid_nxt) begin
      data_nxt = build_beat(32'(beat_nxt), 32'(x_cur), offset_cur ? 8'(row_nxt) : 8'd0);
      last_nxt = (beat_nxt == last_beat_cur);
      user_nxt[TUSER_SOF] = (beat_nxt == BEAT_ZERO) && (row_nxt == ROW_ZERO);
      user_nxt[TUSER_SOL] = (beat_nxt == BEAT_ZERO) && (row_nxt != ROW_ZERO);
      user_nxt[TUSER_EOF] = last_nxt && (row_nxt == last_row_cur);
      user_nxt[TUSER_EOL] = last_nxt && (row_nxt != last_row_cur);
    end else begin
      data_nxt = 64'd0;
    end
  end

  // Registered stream and status outputs.
  always_ff @(posedge aclk or posedge aclk_reset) begin
    if (aclk_reset) begin
      aclk_tvalid     <= 1'b0;
      aclk_tdata      <= 64'd0;
      aclk_tuser      <= 4'b0000;
      aclk_tlast      <= 1'b0;
      aclk_busy       <= 1'b0;
      aclk_frame_done <= 1'b0;
    end else begin
      aclk_tvalid     <= valid_nxt;
      aclk_tdata      <= data_nxt;
      aclk_tuser      <= user_nxt;
      aclk_tlast      <= last_nxt;
      aclk_busy       <= (state_nxt == ST_ROW) || (state_nxt == ST_GAP);
      aclk_frame_done <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_x_ramp_streamer.sv
// Directed self-checking bench for x_ramp_streamer: ramp frames, flags, gaps,
// back-pressure, ignored starts and asynchronous reset mid-frame.
module tb_x_ramp_streamer;

  logic        aclk;
  logic        aclk_reset;
  logic        aclk_start;
  logic [15:0] aclk_x_size;
  logic [15:0] aclk_y_size;
  logic [15:0] aclk_line_gap;
  logic        aclk_row_offset;
  logic        aclk_tready;
  logic        aclk_tvalid;
  logic [63:0] aclk_tdata;
  logic [3:0]  aclk_tuser;
  logic        aclk_tlast;
  logic        aclk_busy;
  logic        aclk_frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [71:0] cap_first, cap_last, cap_row1;
  int row0_beats;

  x_ramp_streamer #(.X_SIZE_W(16), .Y_SIZE_W(16)) dut (
    .aclk            (aclk),
    .aclk_reset      (aclk_reset),
    .aclk_start      (aclk_start),
    .aclk_x_size     (aclk_x_size),
    .aclk_y_size     (aclk_y_size),
    .aclk_line_gap   (aclk_line_gap),
    .aclk_row_offset (aclk_row_offset),
    .aclk_tready     (aclk_tready),
    .aclk_tvalid     (aclk_tvalid),
    .aclk_tdata      (aclk_tdata),
    .aclk_tuser      (aclk_tuser),
    .aclk_tlast      (aclk_tlast),
    .aclk_busy       (aclk_busy),
    .aclk_frame_done (aclk_frame_done)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] stream_word();
    return {3'b000, aclk_tuser, aclk_tlast, aclk_tdata};
  endfunction

  // Expected {pad, tuser, tlast, tdata} for row r, beat b.
  function automatic logic [71:0] model_beat(input int xs, input int ys, input int r,
                                             input int b, input bit off);
    logic [63:0] d;
    logic [3:0]  u;
    int bpr, px;
    bit lst;
    bpr = (xs + 7) / 8;
    d = 64'd0;
    for (int k = 0; k < 8; k++) begin
      px = b * 8 + k;
      if (px < xs) d[k*8 +: 8] = 8'((px + (off ? r : 0)) % 256);
    end
    lst = (b == bpr - 1);
    u = 4'b0000;
    if (b == 0) u = (r == 0) ? 4'b0001 : 4'b0100;
    if (lst) u = u | ((r == ys - 1) ? 4'b0010 : 4'b1000);
    return {3'b000, u, lst, d};
  endfunction

  task automatic run_frame(input int xs, input int ys, input int gp, input bit off,
                           input bit rnd, input bit inject, input int stop_row,
                           input int stop_beat);
    int r, b, bpr, gap_seen, cyc;
    bit fin, stopped;
    bpr = (xs + 7) / 8;
    r = 0; b = 0; gap_seen = 0; cyc = 0; fin = 1'b0; stopped = 1'b0;
    row0_beats = 0;
    @(negedge aclk);
    aclk_x_size     = 16'(xs);
    aclk_y_size     = 16'(ys);
    aclk_line_gap   = 16'(gp);
    aclk_row_offset = off;
    aclk_tready     = 1'b1;
    aclk_start      = 1'b1;
    @(negedge aclk);
    aclk_start = 1'b0;
    check_eq("start_tvalid", 72'(aclk_tvalid), 72'(1));
    check_eq("start_busy", 72'(aclk_busy), 72'(1));
    while (!fin && !stopped && cyc < 20000) begin
      if (inject && cyc == 0) begin
        aclk_start      = 1'b1;
        aclk_x_size     = 16'd1;
        aclk_row_offset = 1'b0;
      end else begin
        aclk_start = 1'b0;
      end
      aclk_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (aclk_tvalid) begin
        if (r == stop_row && b == stop_beat) begin
          stopped = 1'b1;
        end else begin
          check_eq("beat", stream_word(), model_beat(xs, ys, r, b, off));
          if (b == 0 && r > 0) begin
            check_eq("gap_len", 72'(gap_seen), 72'(gp));
            gap_seen = 0;
          end
          if (r == 0 && b == 0) cap_first = stream_word();
          if (r == 1 && b == 0) cap_row1 = stream_word();
          if (r == ys - 1 && b == bpr - 1) cap_last = stream_word();
          if (aclk_tready) begin
            if (r == 0) row0_beats++;
            if (b == bpr - 1) begin
              b = 0;
              if (r == ys - 1) fin = 1'b1;
              else r++;
            end else begin
              b++;
            end
          end
        end
      end else begin
        check_eq("gap_zero", stream_word(), 72'(0));
        check_eq("gap_busy", 72'(aclk_busy), 72'(1));
        gap_seen++;
      end
      if (!stopped) @(negedge aclk);
      cyc++;
    end
    aclk_start = 1'b0;
    if (fin) begin
      check_eq("done_pulse", 72'(aclk_frame_done), 72'(1));
      check_eq("done_busy", 72'(aclk_busy), 72'(0));
      check_eq("done_idle", {71'(0), aclk_tvalid} | stream_word(), 72'(0));
      @(negedge aclk);
      check_eq("done_once", 72'(aclk_frame_done), 72'(0));
      check_eq("after_tvalid", 72'(aclk_tvalid), 72'(0));
    end else if (!stopped) begin
      check_eq("timeout", 72'(0), 72'(1));
    end
  endtask

  task automatic zero_size(input int xs, input int ys);
    @(negedge aclk);
    aclk_x_size = 16'(xs);
    aclk_y_size = 16'(ys);
    aclk_start  = 1'b1;
    @(negedge aclk);
    aclk_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("zero_busy", 72'(aclk_busy), 72'(0));
      check_eq("zero_tvalid", 72'(aclk_tvalid), 72'(0));
      check_eq("zero_done", 72'(aclk_frame_done), 72'(0));
      @(negedge aclk);
    end
  endtask

  initial begin
    aclk_reset      = 1'b1;
    aclk_start      = 1'b0;
    aclk_x_size     = 16'd0;
    aclk_y_size     = 16'd0;
    aclk_line_gap   = 16'd0;
    aclk_row_offset = 1'b0;
    aclk_tready     = 1'b1;
    @(negedge aclk);
    check_eq("reset_stream", stream_word(), 72'(0));
    check_eq("reset_status", {70'(0), aclk_busy, aclk_frame_done}, 72'(0));
    aclk_reset = 1'b0;
    @(negedge aclk);
    check_eq("idle_tvalid", 72'(aclk_tvalid), 72'(0));

    // 256x4, no gap, always ready
    run_frame(256, 4, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("x256_row_beats", 72'(row0_beats), 72'(32));
    check_eq("x256_first", cap_first, {3'b000, 4'b0001, 1'b0, 64'h0706050403020100});
    check_eq("x256_last", cap_last, {3'b000, 4'b0010, 1'b1, 64'hFFFEFDFCFBFAF9F8});

    // 13x2: partial last beat
    run_frame(13, 2, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("x13_row_beats", 72'(row0_beats), 72'(2));
    check_eq("x13_last", cap_last, {3'b000, 4'b0010, 1'b1, 64'h0000000C0B0A0908});
    check_eq("x13_row1_first", cap_row1, {3'b000, 4'b0100, 1'b0, 64'h0706050403020100});

    // 64x3 with random back-pressure
    run_frame(64, 3, 0, 1'b0, 1'b1, 1'b0, -1, -1);
    check_eq("x64_row_beats", 72'(row0_beats), 72'(8));

    // 16x3 with 5-cycle line gaps
    run_frame(16, 3, 5, 1'b0, 1'b0, 1'b0, -1, -1);

    // 8x2 with row offset and a start pulse plus config change mid-frame
    run_frame(8, 2, 0, 1'b1, 1'b0, 1'b1, -1, -1);
    check_eq("off_row1", cap_row1, {3'b000, 4'b0110, 1'b1, 64'h0807060504030201});
    check_eq("off_row0", cap_first, {3'b000, 4'b1001, 1'b1, 64'h0706050403020100});

    zero_size(0, 4);
    zero_size(8, 0);

    // Reset mid-frame at row 1 beat 3
    run_frame(64, 3, 0, 1'b0, 1'b0, 1'b0, 1, 3);
    #2 aclk_reset = 1'b1;
    #1;
    check_eq("rst_async_stream", stream_word(), 72'(0));
    check_eq("rst_async_status", {70'(0), aclk_busy, aclk_frame_done}, 72'(0));
    check_eq("rst_async_tvalid", 72'(aclk_tvalid), 72'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check_eq("rst_hold_done", 72'(aclk_frame_done), 72'(0));
    end
    aclk_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check_eq("rst_release_idle", {69'(0), aclk_tvalid, aclk_busy, aclk_frame_done}, 72'(0));
    end

    // 1x1 frame after reset
    run_frame(1, 1, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("x1_beat", cap_first, {3'b000, 4'b0011, 1'b1, 64'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/x_ramp_streamer.md
X_RAMP_STREAMER -- requirements
Module: x_ramp_streamer

Interface
REQ-001 SHALL have parameter X_SIZE_W, default 16, meaning width of the row-size and pixel counters.
REQ-002 SHALL have parameter Y_SIZE_W, default 16, meaning width of the row-count counter.
REQ-003 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port aclk_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port aclk_start, input, 1, one-cycle frame start request.
REQ-006 SHALL have port aclk_x_size, input, X_SIZE_W, pixels per row (one byte each).
REQ-007 SHALL have port aclk_y_size, input, Y_SIZE_W, rows per frame.
REQ-008 SHALL have port aclk_line_gap, input, 16, idle cycles inserted between rows.
REQ-009 SHALL have port aclk_row_offset, input, 1, which adds the row index to the pixel value when 1.
REQ-010 SHALL have port aclk_tready, input, 1, the downstream AXI-stream ready.
REQ-011 SHALL have port aclk_tvalid, output, 1, the AXI-stream valid.
REQ-012 SHALL have port aclk_tdata, output, 64, eight pixels with pixel n in byte n.
REQ-013 SHALL have port aclk_tuser, output, 4, sync flags: [0] SOF, [1] EOF, [2] SOL, [3] EOL.
REQ-014 SHALL have port aclk_tlast, output, 1, marking the last beat of each row.
REQ-015 SHALL have port aclk_busy, output, 1, high from frame acceptance until the last beat is accepted.
REQ-016 SHALL have port aclk_frame_done, output, 1, a one-cycle pulse at frame end.

Function
REQ-017 SHALL sample aclk_start only in IDLE; a start while busy SHALL be ignored.
REQ-018 SHALL latch all configuration inputs on an accepted start; later input changes SHALL NOT affect the current frame.
REQ-019 SHALL ignore a start when x_size=0 or y_size=0: busy stays 0, no beats, no frame_done.
REQ-020 SHALL use states IDLE, ROW, GAP and DONE, with transitions: IDLE->ROW on accepted start; ROW->GAP on last-beat handshake when rows remain and gap>0; ROW->ROW on the same handshake with gap=0; ROW->DONE on the last beat of the last row; GAP->ROW when the gap counter expires; DONE->IDLE after one cycle.
REQ-021 SHALL assert tvalid the cycle after an accepted start, with no other latency.
REQ-022 SHALL produce ceil(x_size/8) beats per row.
REQ-023 SHALL set byte k of a beat to (x + (row_offset ? row : 0)) mod 256, where x = beat*8+k; unused bytes of a partial last beat SHALL be 0.
REQ-024 SHALL, once tvalid is high, hold tdata/tuser/tlast stable until tready=1; the beat advances only on a tvalid&tready handshake.
REQ-025 SHALL set tuser[0] on the first beat of row 0 and tuser[2] on the first beat of every other row.
REQ-026 SHALL set tlast on the last beat of every row, plus tuser[1] on the last row or tuser[3] otherwise.
REQ-027 SHALL, for a single-beat row, OR the first-beat and last-beat flags together; for example, a 1x1 frame gives tuser=0011 and tlast=1.
REQ-028 SHALL hold tvalid=0 for exactly line_gap cycles between rows; gap=0 gives back-to-back rows.
REQ-029 SHALL drive tvalid=0 and tdata/tuser/tlast=0 whenever no beat is valid.
REQ-030 SHALL pulse frame_done in DONE, i.e. one cycle after the final handshake, and busy SHALL fall in the same cycle.
REQ-031 SHALL keep the 16-bit gap counter and the row/pixel counters from wrapping inside a frame; maximum values SHALL complete correctly.

Reset
REQ-032 SHALL, on aclk_reset assertion, immediately force state IDLE and drive tvalid, tlast, tuser, tdata, busy and frame_done to 0, including mid-frame.
REQ-033 SHALL NOT resume an aborted frame after reset release; a new start is required.

Structure
REQ-034 SHALL place the tuser bit-index constants (SOF=0, EOF=1, SOL=2, EOL=3) and the state enum in the shared package xgs_stream_pkg.
REQ-035 SHALL be implemented as a single module with no sub-module; beat assembly SHALL be a package function.

Verification
REQ-036 SHALL cover: x=256, y=4, gap=0, tready=1 -> 32 beats/row; row0 beat0 = 0x0706050403020100 with tuser=0001; row3 last beat has tuser=0010 and tlast=1; frame_done pulses once.
REQ-037 SHALL cover: x=13, y=2 -> 2 beats/row; last beat = 0x0000000C0B0A0908 with tlast=1; row1 first beat has tuser=0100.
REQ-038 SHALL cover: random tready (50%) with x=64, y=3 -> identical beat sequence to tready=1 and data stable while stalled.
REQ-039 SHALL cover: gap=5, y=3 -> exactly 5 tvalid=0 cycles after each of rows 0 and 1, and none after row 2.
REQ-040 SHALL cover: row_offset=1, x=8, y=2 -> row1 beat = 0x0807060504030201; a start pulse mid-frame is ignored.
REQ-041 SHALL cover: reset asserted at row 1 beat 3 -> all outputs 0 asynchronously, no frame_done, idle after release.
